// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encoding and response-checker FSM states.
package alu_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } chk_state_t;

endpackage

// File: rtl/alu_ref_model.sv
// Golden combinational ALU function; reusable by any checker of the integer ALU.
module alu_ref_model
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] expected
);

    // ADD keeps the low WIDTH bits; the carry is intentionally dropped
    always_comb begin
        expected = '0;
        case (op)
            OP_AND:  expected = a & b;
            OP_OR:   expected = a | b;
            OP_XOR:  expected = a ^ b;
            OP_ADD:  expected = WIDTH'(a + b);
            default: expected = '0;
        endcase
    end

endmodule

// File: rtl/alu_result_checker.sv
// On-chip response checker for the integer ALU: recomputes each result,
// counts passes/fails and captures the first mismatching transaction.
module alu_result_checker
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned CNT_W       = 8,
    parameter bit          STOP_ON_ERR = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             halted,
    output logic             err_flag,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [1:0]       err_op,
    output logic [WIDTH-1:0] err_a,
    output logic [WIDTH-1:0] err_b,
    output logic [WIDTH-1:0] err_result,
    output logic [WIDTH-1:0] err_expected
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    chk_state_t       state;
    logic             stage_valid;
    logic [1:0]       stage_op;
    logic [WIDTH-1:0] stage_a;
    logic [WIDTH-1:0] stage_b;
    logic [WIDTH-1:0] stage_result;
    logic [WIDTH-1:0] expected;
    logic             mismatch;
    logic             accept;

    alu_ref_model #(.WIDTH(WIDTH)) u_ref (
        .op       (stage_op),
        .a        (stage_a),
        .b        (stage_b),
        .expected (expected)
    );

    assign mismatch = stage_valid && (expected != stage_result);
    // Ready falls in the failing compare cycle so nothing follows a mismatch
    assign in_ready = !halted && !(STOP_ON_ERR && mismatch);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);
    assign halted   = (state == HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            stage_valid  <= 1'b0;
            stage_op     <= '0;
            stage_a      <= '0;
            stage_b      <= '0;
            stage_result <= '0;
            err_flag     <= 1'b0;
            pass_cnt     <= '0;
            fail_cnt     <= '0;
            err_op       <= '0;
            err_a        <= '0;
            err_b        <= '0;
            err_result   <= '0;
            err_expected <= '0;
        end else if (clear) begin
            state        <= IDLE;
            stage_valid  <= 1'b0;
            err_flag     <= 1'b0;
            pass_cnt     <= '0;
            fail_cnt     <= '0;
            err_op       <= '0;
            err_a        <= '0;
            err_b        <= '0;
            err_result   <= '0;
            err_expected <= '0;
        end else begin
            stage_valid <= accept;
            if (accept) begin
                stage_op     <= op;
                stage_a      <= a;
                stage_b      <= b;
                stage_result <= result;
            end

            if (mismatch) begin
                if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_W'(1);
                if (!err_flag) begin
                    err_op       <= stage_op;
                    err_a        <= stage_a;
                    err_b        <= stage_b;
                    err_result   <= stage_result;
                    err_expected <= expected;
                end
                err_flag <= 1'b1;
            end else if (stage_valid) begin
                if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_W'(1);
            end

            case (state)
                IDLE:    if (accept) state <= RUN;
                RUN:     if (STOP_ON_ERR && mismatch) state <= HALT;
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_checker.sv
// Scoreboard bench for alu_result_checker: one halting and one free-running instance.
module tb_alu_result_checker;

    localparam int CMAX = 15;

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic [3:0] expv;
    } txn_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic [1:0] op;
    logic [3:0] a, b, result;

    logic       rdy [2];
    logic       bsy [2];
    logic       hlt [2];
    logic       ef  [2];
    logic [3:0] pc  [2];
    logic [3:0] fc  [2];
    logic [1:0] eop [2];
    logic [3:0] ea  [2];
    logic [3:0] eb  [2];
    logic [3:0] er  [2];
    logic [3:0] ee  [2];

    int n_vec = 0;
    int n_bad = 0;

    txn_t sb0[$];
    txn_t sb1[$];
    int   m_pass [2];
    int   m_fail [2];
    bit   m_err  [2];
    bit   m_halt [2];
    bit   m_run  [2];
    txn_t m_cap  [2];

    always #5 clk = ~clk;

    alu_result_checker #(.WIDTH(4), .CNT_W(4), .STOP_ON_ERR(1'b1)) dut_stop (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy[0]),
        .op(op), .a(a), .b(b), .result(result), .busy(bsy[0]), .halted(hlt[0]),
        .err_flag(ef[0]), .pass_cnt(pc[0]), .fail_cnt(fc[0]), .err_op(eop[0]),
        .err_a(ea[0]), .err_b(eb[0]), .err_result(er[0]), .err_expected(ee[0])
    );

    alu_result_checker #(.WIDTH(4), .CNT_W(4), .STOP_ON_ERR(1'b0)) dut_free (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy[1]),
        .op(op), .a(a), .b(b), .result(result), .busy(bsy[1]), .halted(hlt[1]),
        .err_flag(ef[1]), .pass_cnt(pc[1]), .fail_cnt(fc[1]), .err_op(eop[1]),
        .err_a(ea[1]), .err_b(eb[1]), .err_result(er[1]), .err_expected(ee[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [3:0] ref_fn(input logic [1:0] o, input logic [3:0] x, input logic [3:0] y);
        logic [4:0] s;
        s = 5'(x) + 5'(y);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return s[3:0];
        endcase
    endfunction

    function automatic bit head_mis(input int d);
        txn_t t;
        if (d == 0) begin
            if (sb0.size() == 0) return 1'b0;
            t = sb0[0];
        end else begin
            if (sb1.size() == 0) return 1'b0;
            t = sb1[0];
        end
        return t.expv != t.res;
    endfunction

    function automatic bit m_ready(input int d);
        return !m_halt[d] && !((d == 0) && head_mis(d));
    endfunction

    task automatic model_clear(input int d);
        if (d == 0) sb0.delete(); else sb1.delete();
        m_pass[d] = 0;
        m_fail[d] = 0;
        m_err[d]  = 1'b0;
        m_halt[d] = 1'b0;
        m_run[d]  = 1'b0;
        m_cap[d]  = '0;
    endtask

    // Advance the reference model by one rising edge
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            bit   acc;
            bit   have;
            txn_t t;
            acc  = in_valid && m_ready(d);
            if (clear) begin
                model_clear(d);
                continue;
            end
            have = (d == 0) ? (sb0.size() != 0) : (sb1.size() != 0);
            if (have) begin
                t = (d == 0) ? sb0.pop_front() : sb1.pop_front();
                if (t.expv != t.res) begin
                    if (m_fail[d] < CMAX) m_fail[d]++;
                    if (!m_err[d]) m_cap[d] = t;
                    m_err[d] = 1'b1;
                    if (d == 0) m_halt[d] = 1'b1;
                end else if (m_pass[d] < CMAX) begin
                    m_pass[d]++;
                end
            end
            if (acc) begin
                t = '{op: op, a: a, b: b, res: result, expv: ref_fn(op, a, b)};
                if (d == 0) sb0.push_back(t); else sb1.push_back(t);
                m_run[d] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("in_ready[%0d]", d), 32'(rdy[d]), 32'(m_ready(d)));
            chk($sformatf("busy[%0d]", d),     32'(bsy[d]), 32'(m_run[d]));
            chk($sformatf("halted[%0d]", d),   32'(hlt[d]), 32'(m_halt[d]));
            chk($sformatf("err_flag[%0d]", d), 32'(ef[d]),  32'(m_err[d]));
            chk($sformatf("pass_cnt[%0d]", d), 32'(pc[d]),  32'(m_pass[d]));
            chk($sformatf("fail_cnt[%0d]", d), 32'(fc[d]),  32'(m_fail[d]));
            chk($sformatf("err_op[%0d]", d),   32'(eop[d]), 32'(m_cap[d].op));
            chk($sformatf("err_a[%0d]", d),    32'(ea[d]),  32'(m_cap[d].a));
            chk($sformatf("err_b[%0d]", d),    32'(eb[d]),  32'(m_cap[d].b));
            chk($sformatf("err_res[%0d]", d),  32'(er[d]),  32'(m_cap[d].res));
            chk($sformatf("err_exp[%0d]", d),  32'(ee[d]),  32'(m_cap[d].expv));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic send(input logic [1:0] o, input logic [3:0] x, input logic [3:0] y, input logic [3:0] r);
        op       = o;
        a        = x;
        b        = y;
        result   = r;
        in_valid = 1'b1;
        step();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic do_clear();
        in_valid = 1'b0;
        clear    = 1'b1;
        step();
        clear    = 1'b0;
    endtask

    initial begin
        logic [4:0] wide;
        rst_n    = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        op       = '0;
        a        = '0;
        b        = '0;
        result   = '0;
        model_clear(0);
        model_clear(1);
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        check_all();

        // XOR pass visible two edges after presentation
        send(2'b10, 4'b1100, 4'b1001, 4'b0101);
        idle(1);
        chk("xor_pass", 32'(pc[0]), 32'd1);
        chk("xor_fail", 32'(fc[0]), 32'd0);
        chk("xor_eflag", 32'(ef[1]), 32'd0);

        // ADD wrap-around, truncated 5-bit result, then a true miss
        do_clear();
        wide = 5'b10000;
        send(2'b11, 4'b1111, 4'b0001, 4'b0000);
        send(2'b11, 4'b1111, 4'b0001, wide[3:0]);
        send(2'b11, 4'b1111, 4'b0001, 4'b0001);
        idle(1);
        chk("wrap_pass", 32'(pc[1]), 32'd2);
        chk("wrap_fail", 32'(fc[1]), 32'd1);
        chk("wrap_err_exp", 32'(ee[1]), 32'd0);
        chk("wrap_err_res", 32'(er[0]), 32'd1);

        // First-error capture and halt
        do_clear();
        send(2'b00, 4'b1010, 4'b0110, 4'b0010);
        send(2'b01, 4'b0000, 4'b0011, 4'b0111);
        chk("halt_ready_drop", 32'(rdy[0]), 32'd0);
        repeat (3) send(2'b10, 4'b1100, 4'b1001, 4'b0101);
        idle(1);
        chk("cap_op", 32'(eop[0]), 32'd1);
        chk("cap_a", 32'(ea[0]), 32'd0);
        chk("cap_b", 32'(eb[0]), 32'd3);
        chk("cap_res", 32'(er[0]), 32'd7);
        chk("cap_exp", 32'(ee[0]), 32'd3);
        chk("cap_halted", 32'(hlt[0]), 32'd1);
        chk("cap_ready", 32'(rdy[0]), 32'd0);
        chk("cap_pass", 32'(pc[0]), 32'd1);
        chk("cap_fail", 32'(fc[0]), 32'd1);
        chk("free_ready", 32'(rdy[1]), 32'd1);

        // Multiple errors on the free-running checker
        do_clear();
        send(2'b11, 4'd1, 4'd1, 4'd0);
        send(2'b00, 4'hf, 4'h0, 4'd1);
        send(2'b01, 4'd1, 4'd2, 4'd0);
        send(2'b10, 4'd5, 4'd5, 4'd0);
        idle(1);
        chk("multi_fail", 32'(fc[1]), 32'd3);
        chk("multi_pass", 32'(pc[1]), 32'd1);
        chk("multi_op", 32'(eop[1]), 32'd3);
        chk("multi_exp", 32'(ee[1]), 32'd2);
        chk("multi_halted", 32'(hlt[1]), 32'd0);

        // Saturation
        do_clear();
        for (int i = 0; i < 20; i++) begin
            logic [3:0] x, y;
            x = 4'($urandom);
            y = 4'($urandom);
            send(2'b10, x, y, x ^ y);
        end
        idle(1);
        chk("sat_pass0", 32'(pc[0]), 32'd15);
        chk("sat_pass1", 32'(pc[1]), 32'd15);

        // clear wins over a same-edge accept
        do_clear();
        op = 2'b00; a = 4'd3; b = 4'd1; result = 4'd1;
        in_valid = 1'b1;
        clear    = 1'b1;
        step();
        clear    = 1'b0;
        idle(2);
        chk("clr_busy", 32'(bsy[0]), 32'd0);
        chk("clr_pass", 32'(pc[0]), 32'd0);
        chk("clr_fail", 32'(fc[1]), 32'd0);

        // Asynchronous reset with a transaction in the stage
        send(2'b01, 4'd4, 4'd2, 4'd6);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_clear(0);
        model_clear(1);
        chk("rst_busy", 32'(bsy[1]), 32'd0);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        chk("rst_pass", 32'(pc[0]), 32'd0);
        chk("rst_pass1", 32'(pc[1]), 32'd0);

        // Randomised traffic with injected errors and occasional clears
        for (int i = 0; i < 300; i++) begin
            logic [1:0] o;
            logic [3:0] x, y, r;
            o = 2'($urandom);
            x = 4'($urandom);
            y = 4'($urandom);
            r = ($urandom_range(0, 7) == 0) ? 4'($urandom) : ref_fn(o, x, y);
            op       = o;
            a        = x;
            b        = y;
            result   = r;
            in_valid = ($urandom_range(0, 3) != 0);
            clear    = ($urandom_range(0, 39) == 0);
            step();
            clear    = 1'b0;
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
